fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode and the immediate extender.
- Owns the PC register and requests instruction words from instruction memory using a req/ready handshake with variable latency.
- Holds the fetched word in an instruction register until decode accepts it; decode forwards instr[31:7] to the extender.
- Accepts redirects (branch/jump target = pc + immext, computed downstream); handles flushing of an outstanding request and misaligned targets.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_unit_pc_reg.sv | 39 +++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_TGT  = 2'd1,
        PC_PEND = 2'd2
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic misaligned(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with next-value select and pc+4 output.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  pc_sel_t     sel,
    input  logic [31:0] target,
    input  logic [31:0] pending,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    assign pc_plus4 = pc + PC_STEP;

    always_comb begin
        pc_next = pc_plus4;
        unique case (sel)
            PC_INC:  pc_next = pc_plus4;
            PC_TGT:  pc_next = target;
            PC_PEND: pc_next = pending;
            default: pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, imem handshake, instruction
// register, redirect flushing and misaligned-target fault.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_fault
);

    state_t      state_q, state_d;
    logic [31:0] pending_q, pending_d;
    logic [31:0] flush_tgt;
    logic        pc_load;
    pc_sel_t     pc_sel;
    logic        instr_load;
    logic        tgt_mis;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (pc_load),
        .sel      (pc_sel),
        .target   (redirect_target),
        .pending  (pending_q),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign tgt_mis   = misaligned(redirect_target);
    assign flush_tgt = redirect ? redirect_target : pending_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        pc_load    = 1'b0;
        pc_sel     = PC_TGT;
        instr_load = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_load = 1'b1;
                        state_d = tgt_mis ? FAULT : FETCH;
                    end else begin
                        instr_load = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    // A misaligned target waits here too; the fault
                    // is raised once the old response retires.
                    pending_d = redirect_target;
                    state_d   = FLUSH;
                end
            end
            FLUSH: begin
                if (imem_ready) begin
                    pc_load = 1'b1;
                    pc_sel  = redirect ? PC_TGT : PC_PEND;
                    state_d = misaligned(flush_tgt) ? FAULT : FETCH;
                end else if (redirect) begin
                    pending_d = redirect_target;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    state_d = tgt_mis ? FAULT : FETCH;
                end else if (instr_ready) begin
                    pc_load = 1'b1;
                    pc_sel  = PC_INC;
                    state_d = FETCH;
                end
            end
            FAULT: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    state_d = tgt_mis ? FAULT : FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pending_q <= '0;
            instr     <= NOP_INSTR;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            if (instr_load) begin
                instr <= imem_rdata;
            end
        end
    end

    assign imem_req    = rst_n && (state_q == FETCH || state_q == FLUSH);
    assign imem_addr   = pc;
    assign instr_valid = (state_q == HOLD);
    assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a behavioural
// model of the fetch rules and a latency-randomized memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    // model: what decode and memory should observe
    logic [31:0] m_pc, m_instr, m_pend;
    bit          m_holding, m_flushing, m_faulted;

    fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .instr           (instr),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    function automatic bit m_req();
        return !m_holding && !m_faulted;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h13; m_pend = 32'h0;
        m_holding = 0; m_flushing = 0; m_faulted = 0;
    endtask

    task automatic model_step(input bit rdy, input logic [31:0] data,
                              input bit rd, input logic [31:0] t,
                              input bit ir);
        logic [31:0] nt;
        if (m_faulted) begin
            if (rd) begin
                m_pc = t;
                m_faulted = (t[1:0] != 0);
            end
        end else if (m_holding) begin
            if (rd) begin
                m_pc = t; m_holding = 0;
                m_faulted = (t[1:0] != 0);
            end else if (ir) begin
                m_pc = m_pc + 4; m_holding = 0;
            end
        end else if (m_flushing) begin
            if (rdy) begin
                nt = rd ? t : m_pend;
                m_pc = nt; m_flushing = 0;
                m_faulted = (nt[1:0] != 0);
            end else if (rd) begin
                m_pend = t;
            end
        end else if (rdy) begin
            if (rd) begin
                m_pc = t;
                m_faulted = (t[1:0] != 0);
            end else begin
                m_instr = data; m_holding = 1;
            end
        end else if (rd) begin
            m_pend = t; m_flushing = 1;
        end
    endtask

    task automatic step(input bit rdy, input bit rd,
                        input logic [31:0] t, input bit ir);
        @(negedge clk); #1;
        imem_ready = rdy && m_req();
        imem_rdata = word(m_pc);
        redirect = rd;
        redirect_target = t;
        instr_ready = ir;
        model_step(imem_ready, imem_rdata, rd, t, ir);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("req", {31'b0, imem_req}, {31'b0, m_req()});
            chk("addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("valid", {31'b0, instr_valid}, {31'b0, m_holding});
            chk("fault", {31'b0, fetch_fault}, {31'b0, m_faulted});
            if (m_holding) chk("instr", instr, m_instr);
        end
    end

    initial begin
        int lat;
        bit rdy, rd, ir;
        logic [31:0] t;
        model_reset();
        #12;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        @(negedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_pc", pc, 32'h0);
        chk("rel_valid", {31'b0, instr_valid}, 32'd0);
        chk("rel_fault", {31'b0, fetch_fault}, 32'd0);

        // zero-wait memory, decode always ready
        step(1, 0, 0, 1); settle();
        chk("zw_instr0", instr, 32'h0000_C0DE);
        chk("zw_valid0", {31'b0, instr_valid}, 32'd1);
        step(1, 0, 0, 1); settle();
        chk("zw_pc1", pc, 32'h4);
        step(1, 0, 0, 1); settle();
        chk("zw_instr1", instr, 32'h0004_C0DE);
        step(0, 0, 0, 1); settle();
        chk("zw_pc2", pc, 32'h8);

        // decode stall in HOLD
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0); settle();
            chk("stall_pc", pc, 32'h8);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        step(0, 0, 0, 1); settle();
        chk("stall_next", pc, 32'hC);

        // three-cycle latency at 0x10
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0); settle();
            chk("lat_addr", imem_addr, 32'h10);
            chk("lat_req", {31'b0, imem_req}, 32'd1);
        end
        step(1, 0, 0, 0); settle();
        chk("lat_instr", instr, 32'h0010_C0DE);
        step(0, 0, 0, 1);

        // redirect while outstanding
        step(1, 1, 32'h40, 0); settle();
        chk("fl_addr0", imem_addr, 32'h40);
        step(0, 1, 32'h200, 0); settle();
        chk("fl_addr1", imem_addr, 32'h40);
        step(0, 0, 0, 0); settle();
        chk("fl_valid", {31'b0, instr_valid}, 32'd0);
        step(1, 0, 0, 0); settle();
        chk("fl_new", imem_addr, 32'h200);
        chk("fl_nv", {31'b0, instr_valid}, 32'd0);
        step(1, 0, 0, 0); settle();
        chk("fl_instr", instr, 32'h0200_C0DE);

        // misaligned redirect in HOLD, then recovery
        step(0, 1, 32'h102, 0); settle();
        chk("ft_fault", {31'b0, fetch_fault}, 32'd1);
        chk("ft_req", {31'b0, imem_req}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 1, 32'h100, 0); settle();
        chk("ft_clear", {31'b0, fetch_fault}, 32'd0);
        chk("ft_addr", imem_addr, 32'h100);

        // pc wrap
        step(1, 1, 32'hFFFF_FFFC, 0); settle();
        chk("wr_p4", pc_plus4, 32'h0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 1); settle();
        chk("wr_pc", pc, 32'h0);
        chk("wr_p4b", pc_plus4, 32'h4);

        // reset mid-request
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        @(negedge clk); #1;
        redirect = 0; instr_ready = 0; imem_ready = 0;
        rst_n = 1'b0;
        #1;
        chk("mr_req", {31'b0, imem_req}, 32'd0);
        chk("mr_valid", {31'b0, instr_valid}, 32'd0);
        chk("mr_pc", pc, 32'h0);
        model_reset();
        @(negedge clk); #1;
        rst_n = 1'b1;

        // randomized traffic
        lat = $urandom_range(0, 3);
        for (int n = 0; n < 3000; n++) begin
            rdy = 0;
            if (m_req()) begin
                if (lat == 0) rdy = 1;
                else lat--;
            end
            rd = ($urandom_range(0, 7) == 0);
            t = $urandom & 32'h0000_03FC;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
            if ($urandom_range(0, 3) == 0)
                t[1:0] = 2'($urandom_range(1, 3));
            ir = $urandom_range(0, 1) == 1;
            step(rdy, rd, t, ir);
            if (imem_ready) lat = $urandom_range(0, 3);
        end

        @(negedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
